// File: rtl/cp0.sv
// cp0 - Coprocessor-0 for the MIPS-lite CPU.
// Holds SR, Cause, EPC and PRId. Raises intreq toward the fetch unit when an
// unmasked hardware interrupt is pending and captures the resume PC on entry.
//
// Ports:
//   clk, reset      clock (rising edge), asynchronous active-high reset
//   sel, din, we    mfc0/mtc0 register number, write data, write strobe
//   eret            eret executing; clears SR.EXL
//   commit, pc      instruction boundary and the resume address at it
//   hwint           level-sensitive external interrupt lines
//   intreq          interrupt request to fetch unit
//   epc             current EPC value (to fetch unit for eret)
//   dout            mfc0 read data, combinational from sel
//
// Build option: CP0_HWINT_SYNC_EN inserts a 2-flop synchronizer on each hwint
// bit for asynchronous sources (adds 2 cycles of latency).

module cp0 #(
  parameter logic [31:0] PRID = 32'h0061_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  sel,
  input  logic [31:0] din,
  input  logic        we,
  input  logic        eret,
  input  logic        commit,
  input  logic [31:0] pc,
  input  logic [5:0]  hwint,
  output logic        intreq,
  output logic [31:0] epc,
  output logic [31:0] dout
);

  localparam logic [4:0] SEL_SR    = 5'd12;
  localparam logic [4:0] SEL_CAUSE = 5'd13;
  localparam logic [4:0] SEL_EPC   = 5'd14;
  localparam logic [4:0] SEL_PRID  = 5'd15;

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic [5:0]  ip;
  logic [31:0] epc_r;
  logic [5:0]  hwint_s;
  logic        take;
  logic [31:0] sr;
  logic [31:0] cause;

`ifdef CP0_HWINT_SYNC_EN
  logic [5:0] sync_q1;
  logic [5:0] sync_q2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= hwint;
      sync_q2 <= sync_q1;
    end
  end

  assign hwint_s = sync_q2;
`else
  assign hwint_s = hwint;
`endif

  // Purely from flops, so no combinational path from inputs into intreq.
  assign intreq = (|(ip & im)) & ie & ~exl;
  assign take   = commit & intreq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im    <= '0;
      exl   <= 1'b0;
      ie    <= 1'b0;
      ip    <= '0;
      epc_r <= '0;
    end else begin
      ip <= hwint_s;
      if (take) begin
        // Entry wins outright: any coincident mtc0 is dropped.
        epc_r <= {pc[31:2], 2'b00};
        exl   <= 1'b1;
      end else begin
        if (we && sel == SEL_SR) begin
          im  <= din[15:10];
          exl <= din[1];
          ie  <= din[0];
        end
        if (we && sel == SEL_EPC)
          epc_r <= {din[31:2], 2'b00};
        // Later assignment overrides an mtc0 write of EXL.
        if (eret)
          exl <= 1'b0;
      end
    end
  end

  assign sr    = {16'h0000, im, 8'h00, exl, ie};
  assign cause = {16'h0000, ip, 10'h000};
  assign epc   = epc_r;

  always_comb begin
    dout = '0;
    case (sel)
      SEL_SR:    dout = sr;
      SEL_CAUSE: dout = cause;
      SEL_EPC:   dout = epc_r;
      SEL_PRID:  dout = PRID;
      default:   dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0.sv
// tb_cp0 - directed, table-driven bench for cp0.
// Each table row gives the inputs for one cycle and the outputs expected in
// that same cycle (before the closing edge), all worked out by hand.

module tb_cp0;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  sel;
  logic [31:0] din;
  logic        we;
  logic        eret;
  logic        commit;
  logic [31:0] pc;
  logic [5:0]  hwint;
  logic        intreq;
  logic [31:0] epc;
  logic [31:0] dout;

  int errors = 0;
  int checks = 0;

  cp0 dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .din    (din),
    .we     (we),
    .eret   (eret),
    .commit (commit),
    .pc     (pc),
    .hwint  (hwint),
    .intreq (intreq),
    .epc    (epc),
    .dout   (dout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  sel;
    logic [31:0] din;
    logic        eret;
    logic        commit;
    logic [31:0] pc;
    logic [5:0]  hwint;
    logic [31:0] x_dout;
    logic [31:0] x_epc;
    logic        x_intreq;
  } vec_t;

  vec_t tv[$];

`ifdef CP0_HWINT_SYNC_EN
  localparam int LAT_EDGES = 3;
`else
  localparam int LAT_EDGES = 1;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic [4:0] s, input logic [31:0] d,
                     input logic er, input logic cm, input logic [31:0] p,
                     input logic [5:0] hw, input logic [31:0] xd,
                     input logic [31:0] xe, input logic xi);
    tv.push_back({w, s, d, er, cm, p, hw, xd, xe, xi});
  endtask

  task automatic idle_inputs();
    we = 1'b0; sel = 5'd0; din = '0; eret = 1'b0; commit = 1'b0; pc = '0; hwint = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int edges;
    reset = 1'b1;
    idle_inputs();

    //   we sel  din           er cm pc            hwint     dout          epc           intreq
    add(1, 12, 32'h0000_0401, 0, 0, 32'h0,        6'h00, 32'h0000_0000, 32'h0,        0); // 0
    add(0, 12, 32'h0,         0, 0, 32'h0,        6'h01, 32'h0000_0401, 32'h0,        0); // 1
    add(0, 13, 32'h0,         0, 0, 32'h0,        6'h01, 32'h0000_0400, 32'h0,        1); // 2
    add(0, 12, 32'h0,         0, 1, 32'h0000_3010,6'h01, 32'h0000_0401, 32'h0,        1); // 3 entry
    add(0, 12, 32'h0,         0, 0, 32'h0,        6'h01, 32'h0000_0403, 32'h0000_3010,0); // 4
    add(0, 12, 32'h0,         1, 0, 32'h0,        6'h01, 32'h0000_0403, 32'h0000_3010,0); // 5 eret
    add(0, 12, 32'h0,         0, 0, 32'h0,        6'h01, 32'h0000_0401, 32'h0000_3010,1); // 6
    add(0, 14, 32'h0,         0, 1, 32'h0000_3016,6'h01, 32'h0000_3010, 32'h0000_3010,1); // 7 entry
    add(0, 12, 32'h0,         0, 0, 32'h0,        6'h00, 32'h0000_0403, 32'h0000_3014,0); // 8
    add(0, 13, 32'h0,         1, 0, 32'h0,        6'h00, 32'h0000_0000, 32'h0000_3014,0); // 9 eret
    add(0, 12, 32'h0,         0, 0, 32'h0,        6'h00, 32'h0000_0401, 32'h0000_3014,0); // 10
    add(1, 12, 32'h0000_0001, 0, 0, 32'h0,        6'h00, 32'h0000_0401, 32'h0000_3014,0); // 11 IM=0
    add(0, 12, 32'h0,         0, 0, 32'h0,        6'h20, 32'h0000_0001, 32'h0000_3014,0); // 12
    add(0, 13, 32'h0,         0, 0, 32'h0,        6'h20, 32'h0000_8000, 32'h0000_3014,0); // 13
    add(1, 14, 32'h0000_3007, 0, 0, 32'h0,        6'h20, 32'h0000_3014, 32'h0000_3014,0); // 14
    add(1, 13, 32'hFFFF_FFFF, 0, 0, 32'h0,        6'h20, 32'h0000_8000, 32'h0000_3004,0); // 15
    add(0, 13, 32'h0,         0, 0, 32'h0,        6'h00, 32'h0000_8000, 32'h0000_3004,0); // 16
    add(0, 15, 32'h0,         0, 0, 32'h0,        6'h00, 32'h0061_3000, 32'h0000_3004,0); // 17
    add(0,  3, 32'h0,         0, 0, 32'h0,        6'h00, 32'h0000_0000, 32'h0000_3004,0); // 18
    add(1, 12, 32'h0000_0401, 0, 0, 32'h0,        6'h01, 32'h0000_0001, 32'h0000_3004,0); // 19
    add(0, 12, 32'h0,         0, 0, 32'h0,        6'h01, 32'h0000_0401, 32'h0000_3004,1); // 20
    add(1, 14, 32'h0000_5000, 0, 1, 32'h0000_3020,6'h01, 32'h0000_3004, 32'h0000_3004,1); // 21 entry+mtc0
    add(0, 14, 32'h0,         0, 0, 32'h0,        6'h00, 32'h0000_3020, 32'h0000_3020,0); // 22
    add(1, 12, 32'h0000_0803, 1, 0, 32'h0,        6'h00, 32'h0000_0403, 32'h0000_3020,0); // 23 eret+mtc0
    add(0, 12, 32'h0,         0, 0, 32'h0,        6'h00, 32'h0000_0801, 32'h0000_3020,0); // 24
    add(1, 12, 32'h0000_0800, 0, 0, 32'h0,        6'h02, 32'h0000_0801, 32'h0000_3020,0); // 25 IE=0
    add(0, 13, 32'h0,         0, 0, 32'h0,        6'h02, 32'h0000_0800, 32'h0000_3020,0); // 26
    add(1, 12, 32'h0000_0801, 0, 0, 32'h0,        6'h02, 32'h0000_0800, 32'h0000_3020,0); // 27
    add(0, 12, 32'h0,         0, 0, 32'h0,        6'h02, 32'h0000_0801, 32'h0000_3020,1); // 28

    // Reset values.
    #2;
    sel = 5'd15;
    #1;
    chk("rst_prid", dout, 32'h0061_3000);
    chk("rst_epc", epc, 32'h0);
    chk("rst_intreq", {31'h0, intreq}, 32'h0);
    sel = 5'd12;
    #1;
    chk("rst_sr", dout, 32'h0);
    @(negedge clk);
    reset = 1'b0;

`ifndef CP0_HWINT_SYNC_EN
    foreach (tv[i]) begin
      @(negedge clk);
      we = tv[i].we; sel = tv[i].sel; din = tv[i].din; eret = tv[i].eret;
      commit = tv[i].commit; pc = tv[i].pc; hwint = tv[i].hwint;
      #2;
      chk($sformatf("v%0d_dout", i), dout, tv[i].x_dout);
      chk($sformatf("v%0d_epc", i), epc, tv[i].x_epc);
      chk($sformatf("v%0d_intreq", i), {31'h0, intreq}, {31'h0, tv[i].x_intreq});
    end

    // Reset during an entry cycle: entry discarded, everything cleared at once.
    @(negedge clk);
    idle_inputs();
    hwint = 6'h02; commit = 1'b1; pc = 32'h0000_4000; sel = 5'd12;
    #2;
    chk("pre_rst_intreq", {31'h0, intreq}, 32'h1);
    reset = 1'b1;
    #1;
    chk("midrst_epc", epc, 32'h0);
    chk("midrst_sr", dout, 32'h0);
    chk("midrst_intreq", {31'h0, intreq}, 32'h0);
    @(posedge clk);
    #1;
    chk("midrst_epc_edge", epc, 32'h0);
    chk("midrst_sr_edge", dout, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
`endif

    // hwint-to-intreq latency, counted in edges after hwint rises.
    do_reset();
    we = 1'b1; sel = 5'd12; din = 32'h0000_0401;
    @(negedge clk);
    idle_inputs();
    hwint = 6'h01;
    edges = 0;
    #1;
    while (intreq !== 1'b1 && edges < 10) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("irq_latency_edges", edges, LAT_EDGES);

    // Intreq holds while waiting for commit, then drops after entry.
    repeat (3) @(negedge clk);
    chk("irq_held", {31'h0, intreq}, 32'h1);
    commit = 1'b1; pc = 32'h0000_3013;
    @(negedge clk);
    commit = 1'b0; sel = 5'd12;
    #1;
    chk("hold_entry_epc", epc, 32'h0000_3010);
    chk("hold_entry_sr", dout, 32'h0000_0403);
    chk("hold_entry_intreq", {31'h0, intreq}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
